// File: rtl/load_store_unit.sv
// Data-memory access stage: classifies a load/store, drives one word-aligned
// request with byte mask, extends the returned lane, reports completion and errors.
module load_store_unit #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_err,
  output logic        o_mem_req,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_mask,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Handshake: the core's i_valid is taken only while o_ready=1; memory
  // completes a request in any cycle where o_mem_req and i_mem_ready are both 1.
  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        off_q;
  logic [2:0]        funct3_q;
  logic              is_load_q;
  logic              illegal, misaligned;
  logic [1:0]        req_err;
  logic [3:0]        lane_mask;
  logic [31:0]       lane_wdata;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_ext;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (i_load == i_store)
      illegal = 1'b1;
    else if (i_store && !(i_funct3 inside {3'b000, 3'b001, 3'b010}))
      illegal = 1'b1;
    else if (i_load && (i_funct3 inside {3'b011, 3'b110, 3'b111}))
      illegal = 1'b1;
    if (i_funct3[1:0] == 2'b01 && i_addr[0])
      misaligned = 1'b1;
    if (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00)
      misaligned = 1'b1;
    req_err = illegal ? 2'b11 : (misaligned ? 2'b01 : 2'b00);
  end

  always_comb begin
    case (i_funct3[1:0])
      2'b00: begin
        lane_mask  = 4'b0001 << i_addr[1:0];
        lane_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask  = 4'b0011 << i_addr[1:0];
        lane_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        lane_mask  = 4'b1111;
        lane_wdata = i_wdata;
      end
    endcase
  end

  always_comb begin
    byte_sel = i_mem_rdata[{off_q, 3'b000} +: 8];
    half_sel = i_mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_valid) state_nxt = (req_err != 2'b00) ? DONE : REQ;
      REQ:  if (i_mem_ready || cnt == CNT_LAST) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready   = 1'b0;
    o_done    = 1'b0;
    o_mem_req = 1'b0;
    case (state)
      IDLE:    o_ready   = 1'b1;
      REQ:     o_mem_req = 1'b1;
      DONE:    o_done    = 1'b1;
      default: o_ready   = 1'b0;
    endcase
  end

  assign o_state = state;

  // Result registers load on the edge entering DONE, so they hold until the next done.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt         <= '0;
      off_q       <= 2'b00;
      funct3_q    <= 3'b000;
      is_load_q   <= 1'b0;
      o_rdata     <= 32'd0;
      o_err       <= 2'b00;
      o_mem_wen   <= 1'b0;
      o_mem_addr  <= 32'd0;
      o_mem_mask  <= 4'd0;
      o_mem_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          off_q     <= i_addr[1:0];
          funct3_q  <= i_funct3;
          is_load_q <= i_load;
          if (req_err != 2'b00) begin
            o_err   <= req_err;
            o_rdata <= 32'd0;
          end else begin
            cnt         <= '0;
            o_mem_wen   <= i_store;
            o_mem_addr  <= {i_addr[31:2], 2'b00};
            o_mem_mask  <= lane_mask;
            o_mem_wdata <= lane_wdata;
          end
        end
        REQ: begin
          if (i_mem_ready) begin
            o_err   <= 2'b00;
            o_rdata <= is_load_q ? load_ext : 32'd0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              o_err   <= 2'b10;
              o_rdata <= 32'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short timeout: vector table of
// accesses plus a hand-written mid-request reset sequence.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_load, i_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata;
  logic        o_ready, o_done;
  logic [31:0] o_rdata;
  logic [1:0]  o_err;
  logic        o_mem_req, o_mem_wen;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_mask;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ready;
  logic [31:0] i_mem_rdata;
  logic [1:0]  o_state;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.TIMEOUT(4), .CNT_W(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_load(i_load),
    .i_store(i_store), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_ready(o_ready), .o_done(o_done), .o_rdata(o_rdata), .o_err(o_err),
    .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
    .o_mem_mask(o_mem_mask), .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata), .o_state(o_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, word;
    int          ready_at;   // ready asserted on this req cycle; 0 = never
    int          exp_nreq;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_mwdata;
    logic        exp_wen;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    int          exp_done;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(string nm, logic ld, logic st, logic [2:0] f3,
      logic [31:0] addr, logic [31:0] wdata, logic [31:0] word, int ready_at,
      int nreq, logic [31:0] maddr, logic [3:0] mask, logic [31:0] mwdata,
      logic wen, logic [31:0] rdata, logic [1:0] err, int done_c);
    vec_t v;
    v.name = nm; v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.word = word; v.ready_at = ready_at; v.exp_nreq = nreq; v.exp_maddr = maddr;
    v.exp_mask = mask; v.exp_mwdata = mwdata; v.exp_wen = wen; v.exp_rdata = rdata;
    v.exp_err = err; v.exp_done = done_c;
    return v;
  endfunction

  task automatic drive_req(input vec_t v);
    @(posedge clk); #1;
    i_valid = 1'b1; i_load = v.ld; i_store = v.st; i_funct3 = v.f3;
    i_addr = v.addr; i_wdata = v.wdata;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int nreq = 0;
    bit done_seen = 0;
    drive_req(v);
    for (int c = 1; c <= 12 && !done_seen; c++) begin
      @(negedge clk);
      if (c == 1) chk({v.name, ".ready_drop"}, {31'd0, o_ready}, 32'd0);
      if (o_mem_req) begin
        nreq++;
        chk({v.name, ".maddr"}, o_mem_addr, v.exp_maddr);
        chk({v.name, ".mask"}, {28'd0, o_mem_mask}, {28'd0, v.exp_mask});
        chk({v.name, ".mwdata"}, o_mem_wdata, v.exp_mwdata);
        chk({v.name, ".wen"}, {31'd0, o_mem_wen}, {31'd0, v.exp_wen});
        i_mem_ready = (v.ready_at == nreq);
        i_mem_rdata = v.word;
      end
      if (o_done) begin
        done_seen = 1;
        chk({v.name, ".done_cycle"}, c, v.exp_done);
        chk({v.name, ".nreq"}, nreq, v.exp_nreq);
        chk({v.name, ".rdata"}, o_rdata, v.exp_rdata);
        chk({v.name, ".err"}, {30'd0, o_err}, {30'd0, v.exp_err});
      end
      @(posedge clk); #1;
      i_mem_ready = 1'b0;
      i_mem_rdata = 32'h0;
    end
    if (!done_seen) chk({v.name, ".done_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    chk({v.name, ".ready_after"}, {31'd0, o_ready}, 32'd1);
    chk({v.name, ".done_pulse"}, {31'd0, o_done}, 32'd0);
    chk({v.name, ".rdata_hold"}, o_rdata, v.exp_rdata);
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1; i_valid = 0; i_load = 0; i_store = 0; i_funct3 = 0;
    i_addr = 0; i_wdata = 0; i_mem_ready = 0; i_mem_rdata = 0;

    // name ld st f3 addr wdata word ready_at nreq maddr mask mwdata wen rdata err done
    vecs.push_back(mkv("lb",    1,0,3'b000,32'h1003,0,32'h80FF1234,1,1,32'h1000,4'b1000,0,0,32'hFFFFFF80,2'b00,2));
    vecs.push_back(mkv("lhu",   1,0,3'b101,32'h2002,0,32'h9ABC5678,1,1,32'h2000,4'b1100,0,0,32'h00009ABC,2'b00,2));
    vecs.push_back(mkv("lh",    1,0,3'b001,32'h2002,0,32'h9ABC5678,1,1,32'h2000,4'b1100,0,0,32'hFFFF9ABC,2'b00,2));
    vecs.push_back(mkv("sb",    0,1,3'b000,32'h0101,32'hA5,32'hDEADBEEF,4,4,32'h0100,4'b0010,32'hA5A5A5A5,1,0,2'b00,5));
    vecs.push_back(mkv("lw_mis",1,0,3'b010,32'h0006,0,0,1,0,0,0,0,0,0,2'b01,1));
    vecs.push_back(mkv("st_bu", 0,1,3'b100,32'h0100,0,0,1,0,0,0,0,0,0,2'b11,1));
    vecs.push_back(mkv("ld_st", 1,1,3'b010,32'h0100,0,0,1,0,0,0,0,0,0,2'b11,1));
    vecs.push_back(mkv("none",  0,0,3'b010,32'h0100,0,0,1,0,0,0,0,0,0,2'b11,1));
    vecs.push_back(mkv("ld_011",1,0,3'b011,32'h0101,0,0,1,0,0,0,0,0,0,2'b11,1));
    vecs.push_back(mkv("lh_mis",1,0,3'b001,32'h5001,0,0,1,0,0,0,0,0,0,2'b01,1));
    vecs.push_back(mkv("tmo",   1,0,3'b010,32'h0040,0,32'h11111111,0,4,32'h0040,4'b1111,0,0,0,2'b10,5));
    vecs.push_back(mkv("rdy_last",1,0,3'b010,32'h0044,0,32'h12345678,4,4,32'h0044,4'b1111,0,0,32'h12345678,2'b00,5));
    vecs.push_back(mkv("lbu",   1,0,3'b100,32'h3002,0,32'h80FF1234,1,1,32'h3000,4'b0100,0,0,32'h000000FF,2'b00,2));
    vecs.push_back(mkv("lw_top",1,0,3'b010,32'hFFFFFFFC,0,32'hCAFEF00D,1,1,32'hFFFFFFFC,4'b1111,0,0,32'hCAFEF00D,2'b00,2));
    vecs.push_back(mkv("sh",    0,1,3'b001,32'h0202,32'h0000BEEF,0,2,2,32'h0200,4'b1100,32'hBEEFBEEF,1,0,2'b00,3));
    vecs.push_back(mkv("lh_lo", 1,0,3'b001,32'h5000,0,32'h00008001,2,2,32'h5000,4'b0011,0,0,32'hFFFF8001,2'b00,3));
    vecs.push_back(mkv("lb_pos",1,0,3'b000,32'h5000,0,32'h0000007F,1,1,32'h5000,4'b0001,0,0,32'h0000007F,2'b00,2));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", {31'd0, o_ready}, 32'd1);
    chk("rst.done", {31'd0, o_done}, 32'd0);
    chk("rst.rdata", o_rdata, 32'd0);
    chk("rst.err", {30'd0, o_err}, 32'd0);
    chk("rst.req", {31'd0, o_mem_req}, 32'd0);
    chk("rst.wen", {31'd0, o_mem_wen}, 32'd0);
    chk("rst.maddr", o_mem_addr, 32'd0);
    chk("rst.mask", {28'd0, o_mem_mask}, 32'd0);
    chk("rst.mwdata", o_mem_wdata, 32'd0);
    chk("rst.state", {30'd0, o_state}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during the second wait cycle of a request: must abort without o_done.
    drive_req(mkv("rst_lw",1,0,3'b010,32'h0080,0,0,0,0,0,0,0,0,0,0,0));
    @(negedge clk);
    chk("midrst.req1", {31'd0, o_mem_req}, 32'd1);
    @(negedge clk);
    chk("midrst.req2", {31'd0, o_mem_req}, 32'd1);
    i_mem_ready = 1'b1;
    i_mem_rdata = 32'h55555555;
    #1 rst = 1'b1;
    #1;
    chk("midrst.req_async", {31'd0, o_mem_req}, 32'd0);
    chk("midrst.ready_async", {31'd0, o_ready}, 32'd1);
    chk("midrst.done_async", {31'd0, o_done}, 32'd0);
    @(negedge clk);
    chk("midrst.done", {31'd0, o_done}, 32'd0);
    chk("midrst.rdata", o_rdata, 32'd0);
    i_mem_ready = 1'b0;
    rst = 1'b0;
    run_vec(mkv("sw_after",0,1,3'b010,32'h0010,32'h11223344,0,1,1,32'h0010,4'b1111,32'h11223344,1,0,2'b00,2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
